// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline result serializer: word/nibble
// geometry and the serializer state type.
package pipeline_pkg;

    localparam int WORD_W = 32;
    localparam int NIB_W  = 4;
    localparam int BEATS  = WORD_W / NIB_W;
    localparam int BEAT_W = $clog2(BEATS);

    typedef enum logic {
        IDLE,
        SHIFT
    } ser_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with asynchronous (combinational) read of the head
// entry, so a consumer can load rd_data on the same edge that pops it.
// Pointers wrap modulo DEPTH; full/empty come from the extra count bit.
module sync_fifo #(
    parameter int  WIDTH = 32,
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // Status flags, qualified enables and the combinational head read.
    // A write into a full FIFO is accepted only alongside a pop; the
    // popped slot is the one being overwritten.
    always_comb begin
        full    = (count == FULL_CNT);
        empty   = (count == '0);
        do_rd   = rd_en && !empty;
        do_wr   = wr_en && (!full || do_rd);
        rd_data = mem[rd_ptr];
    end

    // Storage array; contents need no reset because count gates reads.
    always_ff @(posedge clock) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_wr && !do_rd) begin
                count <= count + (PTR_W+1)'(1);
            end else if (do_rd && !do_wr) begin
                count <= count - (PTR_W+1)'(1);
            end
        end
    end

endmodule

// File: rtl/pipeline_result_serializer.sv
// Buffers 32-bit pipeline result words (valid-only, no backpressure) and
// emits each as eight 4-bit nibbles on a valid/ready stream, with o_last
// marking the final nibble of a word. Words are held in a sync_fifo; the
// word being shifted lives in a separate shift register.
// Build option: define SER_MSB_FIRST_EN to emit nibbles most-significant
// first; default order is least-significant first.
module pipeline_result_serializer
    import pipeline_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [WORD_W-1:0] i_value,
    input  logic              i_valid,
    output logic [NIB_W-1:0]  o_nibble,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_last,
    output logic [PTR_W:0]    o_count,
    output logic              o_overflow
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    ser_state_t        state;
    ser_state_t        state_next;
    logic [BEAT_W-1:0] beat;
    logic [WORD_W-1:0] shift_reg;
    logic              overflow;

    logic              fifo_wr;
    logic              fifo_rd;
    logic [WORD_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [PTR_W:0]    fifo_count;

    logic              handshake;
    logic              last_beat;
    logic              drop;

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (fifo_wr),
        .wr_data (i_value),
        .rd_en   (fifo_rd),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Handshake, pop and write/drop decisions for the current cycle.
    // A pop either starts shifting from IDLE or chains the next word
    // straight after the final beat, so the stream has no bubble.
    always_comb begin
        handshake = (state == SHIFT) && i_ready;
        last_beat = (beat == LAST_BEAT);
        fifo_rd   = !fifo_empty && ((state == IDLE) || (handshake && last_beat));
        fifo_wr   = i_valid && (!fifo_full || fifo_rd);
        drop      = i_valid && fifo_full && !fifo_rd;
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (handshake && last_beat && fifo_empty) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Shift register and beat counter: load on pop, advance on handshake.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shift_reg <= '0;
            beat      <= '0;
        end else if (fifo_rd) begin
            shift_reg <= fifo_head;
            beat      <= '0;
        end else if (handshake) begin
`ifdef SER_MSB_FIRST_EN
            shift_reg <= shift_reg << NIB_W;
`else
            shift_reg <= shift_reg >> NIB_W;
`endif
            beat      <= last_beat ? '0 : beat + BEAT_W'(1);
        end
    end

    // Sticky overflow: set on any dropped input word, cleared only by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

    // Output decode; nibble and last are forced low outside SHIFT.
    always_comb begin
        o_valid    = 1'b0;
        o_nibble   = '0;
        o_last     = 1'b0;
        if (state == SHIFT) begin
            o_valid = 1'b1;
`ifdef SER_MSB_FIRST_EN
            o_nibble = shift_reg[WORD_W-1 -: NIB_W];
`else
            o_nibble = shift_reg[NIB_W-1:0];
`endif
            o_last  = last_beat;
        end
        o_count    = fifo_count;
        o_overflow = overflow;
    end

endmodule

// File: tb/tb_pipeline_result_serializer.sv
// Self-checking bench for pipeline_result_serializer: directed scenarios
// with literal expectations plus a randomized phase, all checked every
// cycle against a queue-based model of the word stream.
module tb_pipeline_result_serializer;

    localparam int DEPTH = 4;
    localparam int PTR_W = $clog2(DEPTH);

    logic        clock   = 1'b0;
    logic        reset   = 1'b0;
    logic [31:0] i_value = '0;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b0;
    logic [3:0]  o_nibble;
    logic        o_valid;
    logic        o_last;
    logic [PTR_W:0] o_count;
    logic        o_overflow;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pipeline_result_serializer #(.DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .i_value    (i_value),
        .i_valid    (i_valid),
        .o_nibble   (o_nibble),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_last     (o_last),
        .o_count    (o_count),
        .o_overflow (o_overflow)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Nibble k (0 = first emitted) of word w.
    function automatic logic [3:0] nib_of(input logic [31:0] w, input int unsigned k);
        logic [31:0] t;
`ifdef SER_MSB_FIRST_EN
        t = w >> (4 * (7 - k));
`else
        t = w >> (4 * k);
`endif
        return t[3:0];
    endfunction

    // ---------------- behavioural model ----------------
    logic [31:0] mq[$];
    logic [31:0] mcur = '0;
    int unsigned midx = 0;
    bit          mbusy = 0;
    bit          movf = 0;
    bit          m_hs;
    bit          m_pop;
    logic [31:0] m_head;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mq.delete();
            mcur  = '0;
            midx  = 0;
            mbusy = 0;
            movf  = 0;
        end else begin
            m_hs   = mbusy && i_ready;
            m_pop  = (mq.size() > 0) && (!mbusy || (m_hs && midx == 7));
            m_head = '0;
            if (m_pop) m_head = mq.pop_front();
            if (i_valid) begin
                if (mq.size() < DEPTH) mq.push_back(i_value);
                else movf = 1;
            end
            if (m_pop) begin
                mbusy = 1;
                mcur  = m_head;
                midx  = 0;
            end else if (m_hs) begin
                if (midx < 7) midx = midx + 1;
                else mbusy = 0;
            end
        end
    end

    // ---------------- per-cycle compare and recording ----------------
    logic [3:0] hs_nib[$];
    bit         hs_last[$];
    int         cyc = 0;
    int         vcycles = 0;
    int         first_v = -1;
    int         last_v = -1;

    always @(negedge clock) begin
        cyc++;
        chk("valid", 32'(o_valid), 32'(mbusy));
        chk("count", 32'(o_count), 32'(mq.size()));
        chk("overflow", 32'(o_overflow), 32'(movf));
        if (mbusy) begin
            chk("nibble", 32'(o_nibble), 32'(nib_of(mcur, midx)));
            chk("last", 32'(o_last), 32'(midx == 7));
        end
        if (o_valid) begin
            vcycles++;
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
        end
        if (o_valid && i_ready && reset) begin
            hs_nib.push_back(o_nibble);
            hs_last.push_back(o_last);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_rec();
        hs_nib.delete();
        hs_last.delete();
        vcycles = 0;
        first_v = -1;
        last_v  = -1;
    endtask

`ifdef SER_MSB_FIRST_EN
    int seq_single[8] = '{8, 7, 6, 5, 4, 3, 2, 1};
    int stall_f_idx   = 7;
`else
    int seq_single[8] = '{1, 2, 3, 4, 5, 6, 7, 8};
    int stall_f_idx   = 0;
`endif

    int nlast;
    int dens;

    initial begin
        // Reset held low with i_valid active: nothing accepted.
        reset = 1'b0; i_valid = 1'b1; i_value = 32'hDEADBEEF; i_ready = 1'b1;
        run(3);
        chk("rst_valid", 32'(o_valid), 32'h0);
        chk("rst_overflow", 32'(o_overflow), 32'h0);
        chk("rst_count", 32'(o_count), 32'h0);
        chk("rst_nibble", 32'(o_nibble), 32'h0);
        chk("rst_last", 32'(o_last), 32'h0);
        i_valid = 1'b0;
        reset   = 1'b1;
        run(3);
        chk("post_rst_count", 32'(o_count), 32'h0);
        chk("post_rst_valid", 32'(o_valid), 32'h0);

        // Single word, latency and nibble order.
        clear_rec();
        i_ready = 1'b1; i_value = 32'h87654321; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        chk("lat_t0_valid", 32'(o_valid), 32'h0);
        chk("lat_t0_count", 32'(o_count), 32'h1);
        tick();
        chk("lat_t1_valid", 32'(o_valid), 32'h1);
        run(20);
        chk("single_hs_count", 32'(hs_nib.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            chk("single_nib", (k < hs_nib.size()) ? 32'(hs_nib[k]) : 32'hFFFF_FFFF, 32'(seq_single[k]));
            chk("single_last", (k < hs_last.size()) ? 32'(hs_last[k]) : 32'hFFFF_FFFF, (k == 7) ? 32'h1 : 32'h0);
        end

        // Stalling consumer: ready pattern 1,0,0,1,0,0,...
        clear_rec();
        i_ready = 1'b1; i_value = 32'h0000000F; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        for (int c = 0; c < 60; c++) begin
            i_ready = (c % 3 == 0);
            tick();
        end
        i_ready = 1'b1;
        chk("stall_hs_count", 32'(hs_nib.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            chk("stall_nib", (k < hs_nib.size()) ? 32'(hs_nib[k]) : 32'hFFFF_FFFF, (k == stall_f_idx) ? 32'hF : 32'h0);
        end

        // Back-to-back words, second arriving 3 cycles after the first.
        clear_rec();
        i_value = 32'h11111111; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        run(2);
        i_value = 32'h22222222; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        run(30);
        chk("b2b_valid_cycles", 32'(vcycles), 32'd16);
        chk("b2b_contiguous", 32'(last_v - first_v + 1), 32'd16);
        chk("b2b_hs_count", 32'(hs_nib.size()), 32'd16);
        nlast = 0;
        foreach (hs_last[k]) if (hs_last[k]) nlast++;
        chk("b2b_last_count", 32'(nlast), 32'd2);
        chk("b2b_last8", (hs_last.size() > 7) ? 32'(hs_last[7]) : 32'hFFFF_FFFF, 32'h1);
        chk("b2b_last16", (hs_last.size() > 15) ? 32'(hs_last[15]) : 32'hFFFF_FFFF, 32'h1);
        chk("b2b_nib9", (hs_nib.size() > 8) ? 32'(hs_nib[8]) : 32'hFFFF_FFFF, 32'h2);

        // Overflow: six consecutive words into a stalled block.
        clear_rec();
        i_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            i_value = 32'hA0B0C000 + 32'(k * 17);
            i_valid = 1'b1;
            tick();
            if (k == 4) chk("ovf_before_6th", 32'(o_overflow), 32'h0);
        end
        i_valid = 1'b0;
        chk("ovf_count", 32'(o_count), 32'd4);
        chk("ovf_flag", 32'(o_overflow), 32'h1);
        i_ready = 1'b1;
        run(60);
        chk("ovf_nibbles", 32'(hs_nib.size()), 32'd40);
        chk("ovf_sticky", 32'(o_overflow), 32'h1);

        // Reset mid-word with two words queued.
        clear_rec();
        i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_value = 32'h5A5A0000 + 32'(k);
            i_valid = 1'b1;
            tick();
        end
        i_valid = 1'b0;
        for (int c = 0; c < 50 && hs_nib.size() < 3; c++) tick();
        chk("mid_reached_beat3", 32'(hs_nib.size()), 32'd3);
        chk("mid_queued", 32'(o_count), 32'd2);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(o_valid), 32'h0);
        chk("mid_rst_nibble", 32'(o_nibble), 32'h0);
        chk("mid_rst_last", 32'(o_last), 32'h0);
        chk("mid_rst_count", 32'(o_count), 32'h0);
        chk("mid_rst_overflow", 32'(o_overflow), 32'h0);
        run(2);
        reset = 1'b1;
        clear_rec();
        run(20);
        chk("mid_no_stale", 32'(vcycles), 32'h0);
        chk("mid_overflow_clear", 32'(o_overflow), 32'h0);

        // Randomized traffic with varying density and occasional resets.
        for (int c = 0; c < 4000; c++) begin
            dens    = (c / 500) % 4;
            i_valid = ($urandom_range(0, 9) < 32'(dens * 3 + 1));
            i_value = $urandom;
            i_ready = (dens == 3) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) != 0);
            reset   = ($urandom_range(0, 999) != 0);
            tick();
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        reset   = 1'b1;
        run(100);
        chk("final_drained_valid", 32'(o_valid), 32'h0);
        chk("final_drained_count", 32'(o_count), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_result_serializer.md
Name: pipeline_result_serializer

Overview:
Receiving end of the arithmetic pipeline's output stream. It accepts 32-bit result words on a valid-only interface, which has no backpressure, and buffers them in a small FIFO. It then emits each word as eight 4-bit nibbles on a valid/ready interface, matching the 4-bit width on the pipeline's input side. It sits between the pipeline's o_value/o_valid outputs and any nibble-wide consumer, such as a debug port or the next pipeline's feeder.

Parameters:
- DEPTH, 4, FIFO depth in 32-bit words; must be a power of 2 and at least 2.
- PTR_W, $clog2(DEPTH), FIFO pointer width; derived, never overridden.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- i_value  input  32  result word from the pipeline.
- i_valid  input  1  i_value is valid this cycle. No ready is returned; a word is lost if it is not accepted.
- o_nibble  output  4  current nibble.
- o_valid  output  1  o_nibble is valid.
- i_ready  input  1  consumer accepts o_nibble this cycle.
- o_last  output  1  o_nibble is the 8th (final) nibble of its word.
- o_count  output  PTR_W+1  number of words held in the FIFO, excluding the word currently being shifted.
- o_overflow  output  1  sticky flag; set when an input word is dropped.

Behaviour:
- Reset (reset=0, asynchronous): all outputs are 0, FIFO pointers are 0, beat counter is 0, state is IDLE. A reset asserted mid-word discards the partial word and all buffered words.
- Write: on a clock edge with i_valid=1, the word is written if the FIFO is not full, or if the FIFO is full and a pop occurs on the same edge.
- Overflow: otherwise the word is dropped and o_overflow is set to 1. o_overflow clears only on reset.
- A handshake is defined as o_valid & i_ready on a rising edge.
- State machine: two states, IDLE and SHIFT, plus a 3-bit beat counter.
  - IDLE: o_valid=0. If the FIFO is non-empty, pop the head into the 32-bit shift register, set beat=0, and go to SHIFT.
  - SHIFT: o_valid=1, o_nibble = shift_reg[3:0], o_last = (beat==7).
  - SHIFT, handshake with beat<7: shift right by 4 and increment beat.
  - SHIFT, handshake with beat==7 and FIFO non-empty: pop the next word into the shift register, set beat=0, and stay in SHIFT. There is no bubble between words.
  - SHIFT, handshake with beat==7 and FIFO empty: go to IDLE.
  - SHIFT, no handshake: o_nibble, o_last and beat hold stable. o_valid never drops until the handshake.
- Latency:
  - A word sampled into an empty, idle block at edge t0 appears as nibble 0 with o_valid=1 after edge t0+1.
  - Throughput is 1 nibble per cycle with i_ready held at 1.
  - The minimum sustainable input spacing without loss is 8 cycles. Bursts up to DEPTH+1 words are absorbed: DEPTH words in the FIFO plus one in the shift register.
- Simultaneous write and pop on the same edge: o_count is unchanged.
- Pointer wrap: pointers wrap modulo DEPTH. Full and empty are resolved with the extra count bit.
- Arithmetic: words are passed through unmodified. There is no sign handling; nibbles are raw bits.

Optional Feature:
- Macro: SER_MSB_FIRST_EN.
- Defined: nibbles are emitted most-significant first (o_nibble = shift_reg[31:28], shift left by 4).
- Undefined (default): least-significant first, as described above.
- Handshake, o_last and latency are identical in both builds.

Decomposition:
- Shared package pipeline_pkg holds:
  - the state typedef {IDLE, SHIFT};
  - localparam WORD_W=32;
  - localparam NIB_W=4;
  - localparam BEATS=WORD_W/NIB_W=8.
- Sub-module: sync_fifo (parameters WIDTH, DEPTH; ports wr_en, wr_data, rd_en, rd_data, full, empty, count).
  - It must be an asynchronous-read FIFO so the head can load in the same cycle as the pop.
- The FSM, shift register and overflow flag remain in pipeline_result_serializer.

Test Plan:
- Reset with i_valid=1 held low-reset → o_valid=0, o_overflow=0, o_count=0; no word is accepted while reset=0.
- Single word 0x87654321 with i_ready=1 → after 2 edges, nibbles 1,2,3,4,5,6,7,8 on consecutive cycles, o_last only on the 8th. With SER_MSB_FIRST_EN the order is 8,7,...,1.
- Word 0x0000000F with i_ready toggling 1,0,0,1,... → nibble 0xF is held through the stall cycles, and exactly 8 handshakes occur.
- Back-to-back: 0x11111111, then 0x22222222 arriving 3 cycles later, with i_ready=1 → 16 contiguous valid cycles with no bubble; o_last at beats 8 and 16.
- Overflow: i_ready=0, then 6 consecutive i_valid words with DEPTH=4 → 5 words are retained (shift register plus 4 in the FIFO), o_count=4, o_overflow=1 from the 6th word. After i_ready=1, exactly 40 nibbles are emitted.
- Reset mid-word: reset asserted at beat 3 of a word with 2 words queued → outputs go to 0 immediately. After release, no stale nibbles are emitted and o_overflow=0.
